ifetch: RTL and testbench

- Instruction fetch sequencer for the 6502 core; sits directly downstream of the program-counter slices.
- Samples the byte read at the current PC and classifies the opcode by length (1–3 bytes).
- Collects the operand bytes and presents a complete instruction to the execute/decode stage over a valid/ready handshake.
- Drives the PC increment (carry_in of the low PC slice) and the sync strobe that qualifies opcode fetch cycles.

---
 rtl/ifetch.sv | 125 ++++++++++++
 tb/tb_ifetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch sequencer: captures opcode plus 0-2 operand bytes at the PC and presents them as one instruction.
// Latency: inst_valid rises the cycle after the last byte is captured; minimum len+1 cycles per instruction.
// Backpressure: rdy=0 freezes fetch; inst_ready=0 holds the instruction; redirect flushes everything to opcode fetch.
module ifetch #(
   parameter logic [7:0] RESET_OPCODE = 8'hEA
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  mem_data,
   input  logic        rdy,
   input  logic        redirect,
   output logic        pc_inc,
   output logic        sync,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [7:0]  inst_opcode,
   output logic [15:0] inst_operand,
   output logic [1:0]  inst_len
);

   typedef enum logic [1:0] {
      S_OPC  = 2'd0,
      S_OP1  = 2'd1,
      S_OP2  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_valid;
   logic [7:0]  r_opcode;
   logic [15:0] r_operand;
   logic [1:0]  r_len;

   logic [1:0]  w_len;
   logic        w_cap;
   logic [3:0]  w_lo;

   // A byte is taken from memory whenever we are fetching, memory is ready and no flush is pending.
   assign w_cap = (r_state != S_HOLD) & rdy & ~redirect;
   assign w_lo  = mem_data[3:0];

   assign pc_inc       = w_cap & ~rst;
   assign sync         = (r_state == S_OPC) & ~rst;
   assign inst_valid   = r_valid;
   assign inst_opcode  = r_opcode;
   assign inst_operand = r_operand;
   assign inst_len     = r_len;

   // Opcode length classification; the BRK/RTI/RTS and JSR exceptions are checked before the column rules.
   always_comb begin
      w_len = 2'd2;
      if (mem_data == 8'h00 || mem_data == 8'h40 || mem_data == 8'h60) begin
         w_len = 2'd1;
      end else if (mem_data == 8'h20) begin
         w_len = 2'd3;
      end else if (w_lo == 4'h8 || w_lo == 4'hA) begin
         w_len = 2'd1;
      end else if (w_lo == 4'hC || w_lo == 4'hD || w_lo == 4'hE) begin
         w_len = 2'd3;
      end else if (w_lo == 4'h9 && mem_data[4]) begin
         w_len = 2'd3;
      end
   end

   // Fetch sequencer: collects bytes on capture cycles, presents the instruction in HOLD until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_OPC;
         r_valid   <= 1'b0;
         r_opcode  <= RESET_OPCODE;
         r_operand <= 16'h0000;
         r_len     <= 2'd1;
      end else if (redirect) begin
         // Flush: any partial or presented instruction is dropped.
         r_state <= S_OPC;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_OPC: begin
               if (w_cap) begin
                  r_opcode  <= mem_data;
                  r_operand <= 16'h0000;
                  r_len     <= w_len;
                  if (w_len == 2'd1) begin
                     r_state <= S_HOLD;
                     r_valid <= 1'b1;
                  end else begin
                     r_state <= S_OP1;
                  end
               end
            end
            S_OP1: begin
               if (w_cap) begin
                  r_operand[7:0] <= mem_data;
                  if (r_len == 2'd2) begin
                     r_state <= S_HOLD;
                     r_valid <= 1'b1;
                  end else begin
                     r_state <= S_OP2;
                  end
               end
            end
            S_OP2: begin
               if (w_cap) begin
                  r_operand[15:8] <= mem_data;
                  r_state         <= S_HOLD;
                  r_valid         <= 1'b1;
               end
            end
            S_HOLD: begin
               // Handshake is independent of memory rdy.
               if (inst_ready) begin
                  r_state <= S_OPC;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= S_OPC;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: a program image is fetched through a bench-side PC.
// Expected instructions are queued at program build time and popped on each accepted handshake.
// Random rdy, inst_ready and redirect exercise stalls, backpressure and flushes.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  mem_data;
   logic        rdy;
   logic        redirect;
   logic        pc_inc;
   logic        sync;
   logic        inst_valid;
   logic        inst_ready;
   logic [7:0]  inst_opcode;
   logic [15:0] inst_operand;
   logic [1:0]  inst_len;

   always #5 clk = ~clk;

   ifetch #(.RESET_OPCODE(8'hEA)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_data     (mem_data),
      .rdy          (rdy),
      .redirect     (redirect),
      .pc_inc       (pc_inc),
      .sync         (sync),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst_opcode  (inst_opcode),
      .inst_operand (inst_operand),
      .inst_len     (inst_len)
   );

   int tests = 0;
   int fails = 0;

   logic [7:0]  prog     [0:511];
   bit          is_start [0:511];
   logic [7:0]  e_op     [0:127];
   logic [15:0] e_opnd   [0:127];
   int          e_len    [0:127];
   int          e_addr   [0:127];
   int          n_inst;
   int          wr_addr;
   int          q[$];

   logic [15:0] pc;
   bit          inc_flag = 1'b0;
   bit          mon_en   = 1'b0;
   bit          redir_pending;
   int          redir_tgt;
   int          rt_idx;

   bit          p_valid = 1'b0;
   bit          p_inc   = 1'b0;
   bit          p_rst   = 1'b1;
   logic [7:0]  p_op;
   logic [15:0] p_opnd;
   logic [1:0]  p_len;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Length of a 6502 opcode from the classification rules.
   function automatic int ref_len(input logic [7:0] op);
      int lo;
      int hi;
      lo = int'(op) % 16;
      hi = int'(op) / 16;
      if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 1;
      if (op == 8'h20) return 3;
      if (lo == 8 || lo == 10) return 1;
      if (lo >= 12 && lo <= 14) return 3;
      if (lo == 9 && (hi % 2) == 1) return 3;
      return 2;
   endfunction

   task automatic add_inst(input logic [7:0] op, input logic [15:0] raw);
      int len;
      len = ref_len(op);
      e_op[n_inst]   = op;
      e_len[n_inst]  = len;
      e_addr[n_inst] = wr_addr;
      prog[wr_addr]  = op;
      if (len == 1) begin
         e_opnd[n_inst] = 16'h0000;
      end else if (len == 2) begin
         e_opnd[n_inst] = {8'h00, raw[7:0]};
         prog[wr_addr + 1]     = raw[7:0];
         is_start[wr_addr + 1] = 1'b0;
      end else begin
         e_opnd[n_inst] = raw;
         prog[wr_addr + 1]     = raw[7:0];
         prog[wr_addr + 2]     = raw[15:8];
         is_start[wr_addr + 1] = 1'b0;
         is_start[wr_addr + 2] = 1'b0;
      end
      wr_addr = wr_addr + len;
      n_inst++;
   endtask

   // Monitor: property checks every cycle, scoreboard pop on each accepted instruction.
   always @(negedge clk) begin
      int idx;
      inc_flag = pc_inc;
      if (mon_en && !rst) begin
         if (!rdy || redirect) check("pc_inc_blocked", {31'd0, pc_inc}, 32'd0);
         if (sync) check("sync_on_opcode_byte", {31'd0, is_start[pc[8:0]]}, 32'd1);
         if (inst_valid && !p_valid && !p_rst) check("valid_latency", {31'd0, p_inc}, 32'd1);
         if (inst_valid && p_valid && !p_rst) begin
            check("hold_opcode",  {24'd0, inst_opcode},  {24'd0, p_op});
            check("hold_operand", {16'd0, inst_operand}, {16'd0, p_opnd});
            check("hold_len",     {30'd0, inst_len},     {30'd0, p_len});
         end
         if (inst_valid && inst_ready && !redirect) begin
            if (q.size() == 0) begin
               check("unexpected_instruction", 32'd1, 32'd0);
            end else begin
               idx = q.pop_front();
               check("opcode",  {24'd0, inst_opcode},  {24'd0, e_op[idx]});
               check("operand", {16'd0, inst_operand}, {16'd0, e_opnd[idx]});
               check("len",     {30'd0, inst_len},     32'(e_len[idx]));
            end
         end
      end
      p_valid = inst_valid;
      p_inc   = pc_inc;
      p_rst   = rst;
      p_op    = inst_opcode;
      p_opnd  = inst_operand;
      p_len   = inst_len;
   end

   initial begin
      int cycles;
      bit seen;

      // Program image: padding of one-byte NOPs, directed prefix, then random instructions.
      for (int i = 0; i < 512; i++) begin
         prog[i]     = 8'hEA;
         is_start[i] = 1'b1;
      end
      n_inst  = 0;
      wr_addr = 0;
      add_inst(8'hEA, 16'h0000);
      add_inst(8'hA9, 16'h0042);
      add_inst(8'h4C, 16'h1234);
      add_inst(8'hB9, 16'h8000);
      add_inst(8'h20, 16'h5A5A);
      add_inst(8'h60, 16'h0000);
      add_inst(8'h00, 16'h0000);
      add_inst(8'h40, 16'h0000);
      add_inst(8'h19, 16'hBEEF);
      add_inst(8'h09, 16'h77FF);
      add_inst(8'h0A, 16'h0000);
      add_inst(8'hAD, 16'hC0DE);
      for (int i = 0; i < 50; i++) begin
         add_inst(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
      end
      for (int i = 0; i < n_inst; i++) q.push_back(i);
      rt_idx = n_inst;
      add_inst(8'h6C, 16'h1234);

      // Reset held for several cycles with memory ready, so state would otherwise assert sync/pc_inc.
      rst        = 1'b1;
      rdy        = 1'b1;
      redirect   = 1'b0;
      inst_ready = 1'b0;
      mem_data   = 8'hEA;
      pc         = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sync",     {31'd0, sync},         32'd0);
      check("rst_pc_inc",   {31'd0, pc_inc},       32'd0);
      check("rst_valid",    {31'd0, inst_valid},   32'd0);
      check("rst_opcode",   {24'd0, inst_opcode},  32'h0000_00EA);
      check("rst_operand",  {16'd0, inst_operand}, 32'd0);
      check("rst_len",      {30'd0, inst_len},     32'd1);

      @(posedge clk);
      #1;
      rst           = 1'b0;
      mon_en        = 1'b1;
      redir_pending = 1'b0;
      mem_data      = prog[pc[8:0]];
      cycles        = 0;
      while (q.size() != 0 && cycles < 20000) begin
         @(posedge clk);
         #1;
         cycles++;
         if (inc_flag) pc = pc + 16'd1;
         if (redir_pending) begin
            pc = 16'(e_addr[redir_tgt]);
            redir_pending = 1'b0;
         end
         redirect   = 1'b0;
         rdy        = ($urandom_range(0, 99) < 80);
         inst_ready = ($urandom_range(0, 99) < 60);
         if (q.size() != 0 && $urandom_range(0, 99) < 3) begin
            redirect      = 1'b1;
            redir_pending = 1'b1;
            if (q.size() > 1 && $urandom_range(0, 1) == 1) begin
               void'(q.pop_front());
            end
            redir_tgt = q[0];
         end
         mem_data = prog[pc[8:0]];
      end
      check("program_completed", {31'd0, (q.size() == 0)}, 32'd1);

      // Reset while an instruction is being presented.
      mon_en     = 1'b0;
      rdy        = 1'b0;
      inst_ready = 1'b0;
      redirect   = 1'b1;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      pc       = 16'(e_addr[rt_idx]);
      mem_data = prog[pc[8:0]];
      rdy      = 1'b1;
      seen     = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (inc_flag) pc = pc + 16'd1;
         mem_data = prog[pc[8:0]];
         seen = inst_valid;
      end
      @(negedge clk);
      check("pre_rst_valid",   {31'd0, inst_valid},   32'd1);
      check("pre_rst_opcode",  {24'd0, inst_opcode},  32'h0000_006C);
      check("pre_rst_operand", {16'd0, inst_operand}, 32'h0000_1234);
      check("pre_rst_len",     {30'd0, inst_len},     32'd3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_sync",   {31'd0, sync},   32'd0);
      check("mid_rst_pc_inc", {31'd0, pc_inc}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rdy = 1'b0;
      @(negedge clk);
      check("post_rst_valid",   {31'd0, inst_valid},   32'd0);
      check("post_rst_opcode",  {24'd0, inst_opcode},  32'h0000_00EA);
      check("post_rst_operand", {16'd0, inst_operand}, 32'd0);
      check("post_rst_len",     {30'd0, inst_len},     32'd1);
      check("post_rst_sync",    {31'd0, sync},         32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
